// File: rtl/multi_accumulator_pkg.sv
// Shared op encodings and the wrap/saturate arithmetic helpers for multi_accumulator.
package multi_accumulator_pkg;

  // Op codes reported on op_code (00 also means "no op selected" internally).
  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  // Arithmetic is carried out in a fixed 64-bit container; callers pass the real
  // total width and use only the low bits of the result. Valid for acc_w < 64.
  localparam int unsigned ARITH_W = 64;

  typedef logic [ARITH_W-1:0] arith_t;

  // Low acc_w bits set.
  function automatic arith_t width_mask(input int unsigned acc_w);
    return (arith_t'(1) << acc_w) - arith_t'(1);
  endfunction

  // Returns {carry, result}. Inputs must already fit in acc_w bits. With saturate
  // set, a carry clamps the result to all ones instead of wrapping.
  function automatic logic [ARITH_W:0] sat_add(input arith_t      total,
                                               input arith_t      operand,
                                               input int unsigned acc_w,
                                               input logic        saturate);
    logic [ARITH_W:0] sum;
    arith_t           mask;
    arith_t           res;
    logic             carry;
    mask  = width_mask(acc_w);
    sum   = {1'b0, total} + {1'b0, operand};
    // Both operands are below 2^acc_w, so anything above acc_w bits is the carry.
    carry = ((sum >> acc_w) != '0);
    res   = sum[ARITH_W-1:0] & mask;
    if (saturate && carry) begin
      res = mask;
    end
    return {carry, res};
  endfunction

  // Returns {borrow, result}. With saturate set, a borrow clamps the result to 0.
  function automatic logic [ARITH_W:0] sat_sub(input arith_t      total,
                                               input arith_t      operand,
                                               input int unsigned acc_w,
                                               input logic        saturate);
    arith_t mask;
    arith_t res;
    logic   borrow;
    mask   = width_mask(acc_w);
    borrow = (operand > total);
    res    = (total - operand) & mask;
    if (saturate && borrow) begin
      res = '0;
    end
    return {borrow, res};
  endfunction

endpackage

// File: rtl/multi_accumulator_button_conditioner.sv
// Synchroniser, stable-count debouncer and rising-edge detector for one raw button.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic            level_q, level_d;
  logic            level_prev_q, level_prev_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Next state: two-stage sync, then accept a level change only after it has
  // differed from the debounced level for DEBOUNCE_CYCLES consecutive samples.
  always_comb begin
    sync1_d      = btn_raw;
    sync2_d      = sync1_q;
    level_d      = level_q;
    level_prev_d = level_q;
    cnt_d        = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CntLast) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      level_q      <= level_d;
      level_prev_q <= level_prev_d;
      cnt_q        <= cnt_d;
    end
  end

  // Single-cycle pulse on the debounced rising edge; releases produce nothing.
  assign press = level_q & ~level_prev_q;

endmodule

// File: rtl/multi_accumulator.sv
// Running-total accumulator driven by debounced add/subtract/clear buttons.
module multi_accumulator
  import multi_accumulator_pkg::*;
#(
  parameter int unsigned DATA_W          = 5,
  parameter int unsigned ACC_W           = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter bit          SATURATE        = 1'b0,
  parameter int unsigned CNT_W           = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] dipswitch,
  input  logic              add_btn,
  input  logic              sub_btn,
  input  logic              clr_btn,
  output logic [ACC_W-1:0]  total,
  output logic              overflow,
  output logic              op_done,
  output logic [1:0]        op_code,
  output logic [CNT_W-1:0]  op_count
);

  logic add_press;
  logic sub_press;
  logic clr_press;

  button_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_add_cond (
    .clk    (clk),
    .rst    (rst),
    .btn_raw(add_btn),
    .press  (add_press)
  );

  button_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_sub_cond (
    .clk    (clk),
    .rst    (rst),
    .btn_raw(sub_btn),
    .press  (sub_press)
  );

  button_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_clr_cond (
    .clk    (clk),
    .rst    (rst),
    .btn_raw(clr_btn),
    .press  (clr_press)
  );

  logic [ACC_W-1:0] total_q, total_d;
  logic             overflow_q, overflow_d;
  logic             op_done_q, op_done_d;
  logic [1:0]       op_code_q, op_code_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;

  logic [1:0]       op_sel;
  logic [ARITH_W:0] add_res;
  logic [ARITH_W:0] sub_res;

  // Upper container bits are zero by construction; fold them into a sink.
  logic unused_res_bits;
  assign unused_res_bits = ^{add_res[ARITH_W-1:ACC_W], sub_res[ARITH_W-1:ACC_W]};

  // Operands zero-extended into the shared arithmetic container.
  always_comb begin
    add_res = sat_add(arith_t'(total_q), arith_t'(dipswitch), ACC_W, SATURATE);
    sub_res = sat_sub(arith_t'(total_q), arith_t'(dipswitch), ACC_W, SATURATE);
  end

  // Op priority: clear beats everything; add and sub together cancel out.
  always_comb begin
    op_sel = OP_NONE;
    if (clr_press) begin
      op_sel = OP_CLR;
    end else if (add_press && !sub_press) begin
      op_sel = OP_ADD;
    end else if (sub_press && !add_press) begin
      op_sel = OP_SUB;
    end
  end

  // Next-state for the result registers; overflow only ever sets except on clear.
  always_comb begin
    total_d    = total_q;
    overflow_d = overflow_q;
    op_code_d  = op_code_q;
    op_count_d = op_count_q;
    op_done_d  = 1'b0;
    unique case (op_sel)
      OP_ADD: begin
        total_d    = add_res[ACC_W-1:0];
        overflow_d = overflow_q | add_res[ARITH_W];
      end
      OP_SUB: begin
        total_d    = sub_res[ACC_W-1:0];
        overflow_d = overflow_q | sub_res[ARITH_W];
      end
      OP_CLR: begin
        total_d    = '0;
        overflow_d = 1'b0;
      end
      OP_NONE: ;
    endcase
    if (op_sel != OP_NONE) begin
      op_code_d  = op_sel;
      op_count_d = op_count_q + CNT_W'(1);
      op_done_d  = 1'b1;
    end
  end

  // Result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      total_q    <= '0;
      overflow_q <= 1'b0;
      op_done_q  <= 1'b0;
      op_code_q  <= OP_NONE;
      op_count_q <= '0;
    end else begin
      total_q    <= total_d;
      overflow_q <= overflow_d;
      op_done_q  <= op_done_d;
      op_code_q  <= op_code_d;
      op_count_q <= op_count_d;
    end
  end

  assign total    = total_q;
  assign overflow = overflow_q;
  assign op_done  = op_done_q;
  assign op_code  = op_code_q;
  assign op_count = op_count_q;

endmodule

// File: tb/tb_multi_accumulator.sv
// Directed bench: a wrap-mode and a saturate-mode accumulator share stimulus; a
// reference model pushes expected results that are checked on every op_done.
module tb_multi_accumulator;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] dip;
  logic       add_btn, sub_btn, clr_btn;

  logic [7:0] total_w, total_s, cnt_w, cnt_s;
  logic       ovf_w, ovf_s, done_w, done_s;
  logic [1:0] code_w, code_s;

  always #5 clk = ~clk;

  multi_accumulator #(
    .DATA_W(5), .ACC_W(8), .DEBOUNCE_CYCLES(4), .SATURATE(1'b0), .CNT_W(8)
  ) u_dut_wrap (
    .clk(clk), .rst(rst), .dipswitch(dip), .add_btn(add_btn), .sub_btn(sub_btn),
    .clr_btn(clr_btn), .total(total_w), .overflow(ovf_w), .op_done(done_w),
    .op_code(code_w), .op_count(cnt_w)
  );

  multi_accumulator #(
    .DATA_W(5), .ACC_W(8), .DEBOUNCE_CYCLES(4), .SATURATE(1'b1), .CNT_W(8)
  ) u_dut_sat (
    .clk(clk), .rst(rst), .dipswitch(dip), .add_btn(add_btn), .sub_btn(sub_btn),
    .clr_btn(clr_btn), .total(total_s), .overflow(ovf_s), .op_done(done_s),
    .op_code(code_s), .op_count(cnt_s)
  );

  typedef struct packed {
    logic [7:0] total;
    logic       ovf;
    logic [1:0] code;
    logic [7:0] count;
  } exp_t;

  exp_t q_w[$];
  exp_t q_s[$];

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state
  int   m_tot_w, m_tot_s, m_cnt;
  logic m_ovf_w, m_ovf_s;
  logic [1:0] m_code;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard, wrap instance: every op_done cycle must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (done_w === 1'b1) begin
      n_cmp++;
      assert (q_w.size() > 0) else begin
        n_fail++;
        $error("FAIL wrap_unexpected_op: pending %0d, required >0", q_w.size());
      end
      if (q_w.size() > 0) begin
        e = q_w.pop_front();
        check("wrap_total", 32'(total_w), 32'(e.total));
        check("wrap_overflow", 32'(ovf_w), 32'(e.ovf));
        check("wrap_op_code", 32'(code_w), 32'(e.code));
        check("wrap_op_count", 32'(cnt_w), 32'(e.count));
      end
    end
  end

  // Scoreboard, saturate instance.
  always @(negedge clk) begin
    exp_t e;
    if (done_s === 1'b1) begin
      n_cmp++;
      assert (q_s.size() > 0) else begin
        n_fail++;
        $error("FAIL sat_unexpected_op: pending %0d, required >0", q_s.size());
      end
      if (q_s.size() > 0) begin
        e = q_s.pop_front();
        check("sat_total", 32'(total_s), 32'(e.total));
        check("sat_overflow", 32'(ovf_s), 32'(e.ovf));
        check("sat_op_code", 32'(code_s), 32'(e.code));
        check("sat_op_count", 32'(cnt_s), 32'(e.count));
      end
    end
  end

  task automatic model_reset();
    m_tot_w = 0; m_tot_s = 0; m_cnt = 0; m_ovf_w = 0; m_ovf_s = 0; m_code = 2'b00;
    q_w.delete();
    q_s.delete();
  endtask

  // Apply one press combination to the model and queue the expected outcome.
  task automatic model_op(input logic a, input logic s, input logic c);
    int d;
    d = int'(dip);
    if (c) begin
      m_tot_w = 0; m_tot_s = 0; m_ovf_w = 0; m_ovf_s = 0; m_code = 2'b11;
    end else if (a && !s) begin
      m_code = 2'b01;
      if (m_tot_w + d > 255) begin m_tot_w = m_tot_w + d - 256; m_ovf_w = 1; end
      else m_tot_w = m_tot_w + d;
      if (m_tot_s + d > 255) begin m_tot_s = 255; m_ovf_s = 1; end
      else m_tot_s = m_tot_s + d;
    end else if (s && !a) begin
      m_code = 2'b10;
      if (d > m_tot_w) begin m_tot_w = m_tot_w - d + 256; m_ovf_w = 1; end
      else m_tot_w = m_tot_w - d;
      if (d > m_tot_s) begin m_tot_s = 0; m_ovf_s = 1; end
      else m_tot_s = m_tot_s - d;
    end else begin
      return;
    end
    m_cnt = (m_cnt + 1) % 256;
    q_w.push_back('{total: 8'(m_tot_w), ovf: m_ovf_w, code: m_code, count: 8'(m_cnt)});
    q_s.push_back('{total: 8'(m_tot_s), ovf: m_ovf_s, code: m_code, count: 8'(m_cnt)});
  endtask

  // Hold a button combination, release it long enough to debounce, confirm drained.
  task automatic press(input logic a, input logic s, input logic c, input int hold);
    @(posedge clk); #1;
    add_btn = a; sub_btn = s; clr_btn = c;
    model_op(a, s, c);
    repeat (hold) @(posedge clk);
    #1;
    add_btn = 0; sub_btn = 0; clr_btn = 0;
    repeat (10) @(posedge clk);
    #1;
    check("wrap_pending_after_press", 32'(q_w.size()), 32'd0);
    check("sat_pending_after_press", 32'(q_s.size()), 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_wrap_total"}, 32'(total_w), 32'd0);
    check({tag, "_wrap_overflow"}, 32'(ovf_w), 32'd0);
    check({tag, "_wrap_op_done"}, 32'(done_w), 32'd0);
    check({tag, "_wrap_op_code"}, 32'(code_w), 32'd0);
    check({tag, "_wrap_op_count"}, 32'(cnt_w), 32'd0);
    check({tag, "_sat_total"}, 32'(total_s), 32'd0);
    check({tag, "_sat_overflow"}, 32'(ovf_s), 32'd0);
    check({tag, "_sat_op_done"}, 32'(done_s), 32'd0);
    check({tag, "_sat_op_code"}, 32'(code_s), 32'd0);
    check({tag, "_sat_op_count"}, 32'(cnt_s), 32'd0);
  endtask

  initial begin
    rst = 1; dip = 0; add_btn = 0; sub_btn = 0; clr_btn = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 0;
    check_reset_state("reset");

    // 1: latency of a clean add, single op_done pulse, long hold gives one op.
    dip = 5'd5;
    @(posedge clk); #1;
    add_btn = 1;
    model_op(1, 0, 0);
    @(posedge clk);                 // edge k: first sample of the raw level
    repeat (5) @(posedge clk);      // edge k+5
    #1;
    check("lat_total_before_update", 32'(total_w), 32'd0);
    check("lat_op_done_before_update", 32'(done_w), 32'd0);
    @(posedge clk); #1;             // edge k+6
    check("lat_total_updated", 32'(total_w), 32'd5);
    check("lat_op_done_pulse", 32'(done_w), 32'd1);
    @(posedge clk); #1;
    check("lat_op_done_one_cycle", 32'(done_w), 32'd0);
    repeat (50) @(posedge clk);
    #1 add_btn = 0;
    repeat (10) @(posedge clk);
    #1;
    check("hold_single_op_count", 32'(cnt_w), 32'd1);
    check("hold_pending", 32'(q_w.size()), 32'd0);

    // 2: glitchy press never accumulates enough stable samples.
    @(posedge clk); #1 add_btn = 1;
    repeat (3) @(posedge clk);
    #1 add_btn = 0;
    @(posedge clk); #1 add_btn = 1;
    repeat (2) @(posedge clk);
    #1 add_btn = 0;
    repeat (12) @(posedge clk);
    #1;
    check("glitch_total", 32'(total_w), 32'(m_tot_w));
    check("glitch_op_count", 32'(cnt_w), 32'(m_cnt));

    // 3: wrap on add, sticky flag through sub, clear resets flag.
    press(0, 0, 1, 8);
    dip = 5'd31;
    for (int i = 0; i < 8; i++) press(1, 0, 0, 8);
    dip = 5'd2;  press(1, 0, 0, 8);
    check("preload_250", 32'(total_w), 32'd250);
    dip = 5'd10; press(1, 0, 0, 8);
    dip = 5'd3;  press(0, 1, 0, 8);
    press(0, 0, 1, 8);

    // 4: saturating borrow and carry (wrap instance runs the same sequence).
    dip = 5'd2; press(1, 0, 0, 8);
    dip = 5'd7; press(0, 1, 0, 8);
    press(0, 0, 1, 8);
    dip = 5'd31;
    for (int i = 0; i < 8; i++) press(1, 0, 0, 8);
    dip = 5'd2;  press(1, 0, 0, 8);
    dip = 5'd31; press(1, 0, 0, 8);
    check("sat_clamp_high", 32'(total_s), 32'd255);
    check("sat_clamp_flag", 32'(ovf_s), 32'd1);
    check("wrap_after_carry", 32'(total_w), 32'd25);

    // 5: simultaneous presses.
    dip = 5'd6; press(1, 0, 0, 8);
    press(1, 1, 0, 8);
    check("add_sub_no_op_count", 32'(cnt_w), 32'(m_cnt));
    press(1, 0, 1, 8);
    check("add_clr_total", 32'(total_w), 32'd0);
    press(1, 0, 0, 8);
    press(0, 1, 1, 8);
    check("clr_sub_code", 32'(code_w), 32'd3);
    check("clr_sub_total", 32'(total_s), 32'd0);

    // 6: reset in the middle of a debounce discards the press.
    dip = 5'd9;
    @(posedge clk); #1 add_btn = 1;
    repeat (3) @(posedge clk);
    #1 rst = 1; add_btn = 0;
    model_reset();
    @(posedge clk); #1 rst = 0;
    repeat (15) @(posedge clk);
    #1;
    check_reset_state("mid_op_reset");

    // 256 ops after reset wrap op_count back to zero.
    dip = 5'd1;
    for (int i = 0; i < 256; i++) press(1, 0, 0, 8);
    check("op_count_wrap_wrap", 32'(cnt_w), 32'(m_cnt));
    check("op_count_wrap_sat", 32'(cnt_s), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
